// File: rtl/miner_pkg.sv
// Shared widths, FSM state type and nonce-range helper for the miner control path.
package miner_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HASH_W  = 256;
  localparam int unsigned TX_W    = 288;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    RUN,
    REPORT
  } state_t;

  // Size of each core's slice of the 2^32 nonce space (needs 33 bits for n == 1).
  function automatic logic [NONCE_W:0] nonce_span(input int unsigned n);
    return (NONCE_W + 1)'(64'h1_0000_0000 / 64'(n));
  endfunction

endpackage

// File: rtl/miner_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module miner_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan requesters starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr) + k) % N);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miner_job_scheduler.sv
// Multi-core job scheduler: latches a job, splits the nonce space across the
// hash cores, arbitrates their candidates and reports those meeting the target.
module miner_job_scheduler
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned HDR_W        = 608,
  parameter int unsigned MULTI_RESULT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [HDR_W+HASH_W-1:0]     rx_data,
  input  logic                        data_ready,
  output logic [HDR_W-1:0]            core_header,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_base,
  output logic [NONCE_W-1:0]          core_nonce_count,
  output logic [NUM_CORES-1:0]        core_start,
  output logic                        core_abort,
  input  logic [NUM_CORES-1:0]        core_valid,
  input  logic [NUM_CORES*HASH_W-1:0] core_hash,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [TX_W-1:0]             tx_data,
  output logic                        send_data,
  output logic                        exhausted,
  output logic                        busy
);

  localparam int unsigned        IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NONCE_W:0]   SPAN  = nonce_span(NUM_CORES);
  localparam logic [NONCE_W-1:0] COUNT = (NUM_CORES == 1) ? '1 : SPAN[NONCE_W-1:0];

  state_t               state;
  logic [HASH_W-1:0]    target;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] done_next;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic                 grant_any;
  logic                 restart;
  logic                 hit;
  logic                 all_done;
  logic [HASH_W-1:0]    sel_hash;
  logic [NONCE_W-1:0]   sel_nonce;

  miner_rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Candidate selection, target compare and exhaustion detection.
  always_comb begin
    req       = (state == RUN && !rst) ? core_valid : '0;
    done_next = done_mask | core_done;
    all_done  = &done_next;
    sel_hash  = '0;
    sel_nonce = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (grant[k]) begin
        sel_hash  = core_hash[k*HASH_W +: HASH_W];
        sel_nonce = core_nonce[k*NONCE_W +: NONCE_W];
      end
    end
    hit      = grant_any && (sel_hash <= target);
    ptr_next = IDX_W'((32'(grant_idx) + 1) % NUM_CORES);
  end

  assign core_ack = grant;
  assign busy     = (state != IDLE);

  // Job registers: every data_ready relatches, whatever the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_header      <= '0;
      target           <= '0;
      core_nonce_base  <= '0;
      core_nonce_count <= '0;
    end else if (data_ready) begin
      core_header      <= rx_data[HDR_W+HASH_W-1:HASH_W];
      target           <= rx_data[HASH_W-1:0];
      core_nonce_count <= COUNT;
      for (int unsigned i = 0; i < NUM_CORES; i++)
        core_nonce_base[i*NONCE_W +: NONCE_W] <= NONCE_W'(64'(i) * 64'(SPAN));
    end
  end

  // Control FSM with registered pulse outputs.
  // A preempting load aborts first and defers core_start to the DISPATCH exit,
  // so cores see the abort one cycle before the new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done_mask  <= '0;
      rr_ptr     <= '0;
      restart    <= 1'b0;
      core_start <= '0;
      core_abort <= 1'b0;
      send_data  <= 1'b0;
      exhausted  <= 1'b0;
      tx_data    <= '0;
    end else begin
      core_start <= '0;
      core_abort <= 1'b0;
      send_data  <= 1'b0;
      exhausted  <= 1'b0;
      done_mask  <= (state == DISPATCH) ? '0 : done_next;
      if (grant_any)
        rr_ptr <= ptr_next;
      if (hit) begin
        tx_data   <= {sel_hash, sel_nonce};
        send_data <= 1'b1;
      end
      if (data_ready) begin
        state <= DISPATCH;
        if (state == IDLE) begin
          core_start <= '1;
          restart    <= 1'b0;
        end else begin
          core_abort <= 1'b1;
          restart    <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          DISPATCH: begin
            state   <= RUN;
            restart <= 1'b0;
            if (restart)
              core_start <= '1;
          end
          RUN: begin
            if (hit) begin
              state      <= REPORT;
              core_abort <= (MULTI_RESULT == 0);
            end else if (all_done && core_valid == '0) begin
              exhausted <= 1'b1;
              state     <= IDLE;
            end
          end
          REPORT: state <= (MULTI_RESULT != 0) ? RUN : IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Bench: two schedulers (stop-on-first-hit and multi-result) share one stimulus
// stream; each is compared every cycle against a behavioural model.
module tb_miner_job_scheduler;

  localparam int NC = 4;
  localparam int HW = 608;
  localparam int M_IDLE = 0, M_DISP = 1, M_RUN = 2, M_REPORT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [HW+255:0]   rx_data;
  logic              data_ready;
  logic [NC-1:0]     core_valid;
  logic [NC*256-1:0] core_hash;
  logic [NC*32-1:0]  core_nonce;
  logic [NC-1:0]     core_done;

  logic [HW-1:0]     hdr_o   [2];
  logic [NC*32-1:0]  base_o  [2];
  logic [31:0]       cnt_o   [2];
  logic [NC-1:0]     start_o [2];
  logic              abort_o [2];
  logic [NC-1:0]     ack_o   [2];
  logic [287:0]      tx_o    [2];
  logic              send_o  [2];
  logic              exh_o   [2];
  logic              busy_o  [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    miner_job_scheduler #(.NUM_CORES(NC), .HDR_W(HW), .MULTI_RESULT(m)) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_data          (rx_data),
      .data_ready       (data_ready),
      .core_header      (hdr_o[m]),
      .core_nonce_base  (base_o[m]),
      .core_nonce_count (cnt_o[m]),
      .core_start       (start_o[m]),
      .core_abort       (abort_o[m]),
      .core_valid       (core_valid),
      .core_hash        (core_hash),
      .core_nonce       (core_nonce),
      .core_done        (core_done),
      .core_ack         (ack_o[m]),
      .tx_data          (tx_o[m]),
      .send_data        (send_o[m]),
      .exhausted        (exh_o[m]),
      .busy             (busy_o[m])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state, one set per instance (index = MULTI_RESULT).
  int           ph     [2];
  int           m_ptr  [2];
  bit           m_rs   [2];
  logic [3:0]   m_mask [2];
  logic [255:0] m_tgt  [2];
  logic [HW-1:0] m_hdr [2];
  logic [127:0] m_base [2];
  logic [31:0]  m_cnt  [2];
  logic [3:0]   m_start[2];
  bit           m_abort[2], m_send[2], m_exh[2];
  logic [287:0] m_tx   [2];

  function automatic int pick(int m);
    if (rst || ph[m] != M_RUN) return -1;
    for (int k = 0; k < NC; k++)
      if (core_valid[(m_ptr[m] + k) % NC]) return (m_ptr[m] + k) % NC;
    return -1;
  endfunction

  task automatic model_step(int m);
    int g;
    bit pass;
    longint span;
    logic [3:0] seen;
    g = pick(m);
    if (rst) begin
      ph[m] = M_IDLE; m_ptr[m] = 0; m_rs[m] = 0; m_mask[m] = '0; m_tgt[m] = '0;
      m_hdr[m] = '0; m_base[m] = '0; m_cnt[m] = '0; m_start[m] = '0;
      m_abort[m] = 0; m_send[m] = 0; m_exh[m] = 0; m_tx[m] = '0;
      return;
    end
    m_start[m] = '0; m_abort[m] = 0; m_send[m] = 0; m_exh[m] = 0;
    seen = m_mask[m] | core_done;
    pass = 0;
    if (g >= 0) begin
      m_ptr[m] = (g + 1) % NC;
      pass = (core_hash[256*g +: 256] <= m_tgt[m]);
      if (pass) begin
        m_tx[m]   = {core_hash[256*g +: 256], core_nonce[32*g +: 32]};
        m_send[m] = 1;
      end
    end
    m_mask[m] = (ph[m] == M_DISP) ? 4'b0 : seen;
    if (data_ready) begin
      if (ph[m] == M_IDLE) begin m_start[m] = '1; m_rs[m] = 0; end
      else begin m_abort[m] = 1; m_rs[m] = 1; end
      span      = 64'h1_0000_0000 / NC;
      m_hdr[m]  = rx_data[HW+255:256];
      m_tgt[m]  = rx_data[255:0];
      m_cnt[m]  = (NC == 1) ? 32'hFFFF_FFFF : 32'(span);
      for (int i = 0; i < NC; i++) m_base[m][32*i +: 32] = 32'(i * span);
      ph[m] = M_DISP;
    end else if (ph[m] == M_DISP) begin
      if (m_rs[m]) m_start[m] = '1;
      m_rs[m] = 0;
      ph[m] = M_RUN;
    end else if (ph[m] == M_RUN) begin
      if (pass) begin
        ph[m] = M_REPORT;
        m_abort[m] = (m == 0);
      end else if (seen == 4'hF && core_valid == 4'h0) begin
        m_exh[m] = 1;
        ph[m] = M_IDLE;
      end
    end else if (ph[m] == M_REPORT) begin
      ph[m] = (m == 1) ? M_RUN : M_IDLE;
    end
  endtask

  task automatic check_outputs(int m);
    check($sformatf("start%0d", m), start_o[m], m_start[m]);
    check($sformatf("abort%0d", m), abort_o[m], m_abort[m]);
    check($sformatf("send%0d", m),  send_o[m],  m_send[m]);
    check($sformatf("exh%0d", m),   exh_o[m],   m_exh[m]);
    check($sformatf("busy%0d", m),  busy_o[m],  ph[m] != M_IDLE);
    check($sformatf("tx%0d", m),    tx_o[m],    m_tx[m]);
    check($sformatf("hdr%0d", m),   hdr_o[m],   m_hdr[m]);
    check($sformatf("base%0d", m),  base_o[m],  m_base[m]);
    check($sformatf("cnt%0d", m),   cnt_o[m],   m_cnt[m]);
  endtask

  // One clock: ack checked mid-cycle, registered outputs #1 after the edge.
  task automatic tick();
    int g;
    #3;
    for (int m = 0; m < 2; m++) begin
      g = pick(m);
      check($sformatf("ack%0d", m), ack_o[m], (g < 0) ? 4'b0 : 4'(1 << g));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m);
    #1;
    for (int m = 0; m < 2; m++) check_outputs(m);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] h;
    for (int i = 0; i < HW/32; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic load_job(input logic [255:0] tgt);
    rx_data = {rand_hdr(), tgt};
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic set_cand(input int c, input logic [255:0] h, input logic [31:0] n);
    core_hash[256*c +: 256] = h;
    core_nonce[32*c +: 32]  = n;
    core_valid[c]           = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [255:0] tgt1, hash2, ha, hb;
  logic [HW-1:0] new_hdr;

  initial begin
    rst = 1'b1; data_ready = 1'b0; rx_data = '0;
    core_valid = '0; core_hash = '0; core_nonce = '0; core_done = '0;
    tgt1 = '0; tgt1[223:208] = 16'hFFFF;
    hash2 = '0; hash2[223:208] = 16'hFFFE; hash2[15:0] = 16'h1234;

    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy_o[0], 1'b0);
    check("rst_tx", tx_o[0], 288'h0);

    // Job load: start pulse, evenly split bases, per-core count.
    load_job(tgt1);
    check("t1_start", start_o[0], 4'hF);
    check("t1_base", base_o[0], {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
    check("t1_count", cnt_o[0], 32'h4000_0000);
    tick();

    // Passing candidate on core 2.
    set_cand(2, hash2, 32'h8000_0005);
    #2 check("t2_ack", ack_o[0], 4'b0100);
    tick();
    core_valid = '0;
    check("t2_send", send_o[0], 1'b1);
    check("t2_tx", tx_o[0], {hash2, 32'h8000_0005});
    check("t2_abort0", abort_o[0], 1'b1);
    check("t2_abort1", abort_o[1], 1'b0);
    tick();

    // hash == target passes; target+1 fails.
    load_job(tgt1); tick();
    set_cand(0, tgt1, 32'h11);
    #2 check("t3_eq_ack", ack_o[0], 4'b0001);
    tick();
    core_valid = '0;
    check("t3_eq_send", send_o[0], 1'b1);
    tick();
    load_job(tgt1); tick();
    set_cand(1, tgt1 + 256'd1, 32'h22);
    #2 check("t3_gt_ack", ack_o[0], 4'b0010);
    tick();
    core_valid = '0;
    check("t3_gt_send", send_o[0], 1'b0);
    check("t3_gt_busy", busy_o[0], 1'b1);
    tick();

    // Multi-result: cores 1 and 3 both pass, reported in order, no abort.
    do_reset();
    load_job(tgt1); tick();
    ha = tgt1 - 256'd5; hb = tgt1 >> 1;
    set_cand(1, ha, 32'hAAAA_0001);
    set_cand(3, hb, 32'hBBBB_0003);
    tick();
    core_valid = 4'b1000;
    check("t4_send_a", send_o[1], 1'b1);
    check("t4_tx_a", tx_o[1], {ha, 32'hAAAA_0001});
    tick();
    check("t4_noabort", abort_o[1], 1'b0);
    tick();
    core_valid = '0;
    check("t4_send_b", send_o[1], 1'b1);
    check("t4_tx_b", tx_o[1], {hb, 32'hBBBB_0003});
    tick();

    // Exhaustion: all cores done, no candidates.
    do_reset();
    load_job(tgt1); tick();
    core_done = 4'hF;
    tick();
    core_done = '0;
    check("t5_exh", exh_o[0], 1'b1);
    check("t5_busy", busy_o[0], 1'b0);
    check("t5_nosend", send_o[0], 1'b0);
    tick();
    check("t5_pulse", exh_o[0], 1'b0);

    // Preempt mid-run, then reset mid-run.
    load_job(tgt1); tick();
    new_hdr = rand_hdr();
    rx_data = {new_hdr, rand256()};
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t6_abort", abort_o[0], 1'b1);
    check("t6_nostart", start_o[0], 4'h0);
    check("t6_hdr", hdr_o[0], new_hdr);
    tick();
    check("t6_start", start_o[0], 4'hF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_busy", busy_o[0], 1'b0);
    check("t6_rst_hdr", hdr_o[0], '0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      data_ready = ($urandom_range(0, 29) == 0);
      if (data_ready) begin
        ha = rand256();
        if ($urandom_range(0, 1) == 1) ha[255:200] = '0;
        rx_data = {rand_hdr(), ha};
      end
      core_valid = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 3))
          0: core_hash[256*c +: 256] = m_tgt[0];
          1: core_hash[256*c +: 256] = m_tgt[0] + 256'd1;
          2: core_hash[256*c +: 256] = m_tgt[0] - 256'd1;
          default: core_hash[256*c +: 256] = rand256();
        endcase
        core_nonce[32*c +: 32] = $urandom;
      end
      core_done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
